cdb_scheduler: RTL
==================

CDB_SCHEDULER -- requirements
Module: cdb_scheduler

Interface
REQ-001 The block SHALL have parameter WIDTH, default 31, meaning MSB index of result and target fields.
REQ-002 The block SHALL have parameter ROB, default 2, meaning MSB index of ROB tag.
REQ-003 The block SHALL have parameter CONTROL, default 5, meaning MSB index of pcControl field.
REQ-004 The block SHALL have parameter DEPTH, default 2, meaning entries per requester buffer (power of two, >=2).
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 flush  in  1  mispredict flush; discard all buffered and incoming results.
REQ-008 reqValid  in  [3:0]  per-requester result offer (0=ALU, 1=branch, 2=LSU, 3=MUL).
REQ-009 reqReady  out  [3:0]  per-requester buffer can accept.
REQ-010 reqResult/reqTarget  in  4 x WIDTH+1  result and branch target per requester.
REQ-011 reqRob  in  4 x ROB+1; reqIsControl  in  [3:0]; reqPcControl  in  4 x CONTROL+1.
REQ-012 cdbValid  out  1; cdbResult/cdbTarget  out  WIDTH+1; cdbRob  out  ROB+1; cdbIsControl  out  1; cdbPcControl  out  CONTROL+1; cdbSource  out  2  granted requester index.

Function
REQ-013 Requester i SHALL push its payload into buffer i on a rising edge where reqValid[i] and reqReady[i] are both high.
REQ-014 reqReady[i] SHALL equal (count[i] < DEPTH), from registered count only; no combinational path from reqValid or grant.
REQ-015 Each cycle, the arbiter SHALL grant exactly one non-empty buffer, searching round-robin from pointer upward with wrap 3->0; no grant when all buffers empty.
REQ-016 On a grant to i, the head of buffer i SHALL pop and its payload, with cdbSource=i and cdbValid=1, SHALL register onto cdb outputs at the same edge.
REQ-017 With no grant, cdbValid SHALL be 0 next cycle and the other cdb outputs SHALL hold.
REQ-018 pointer SHALL update to (granted index + 1) mod 4 on a grant and hold otherwise.
REQ-019 Latency: a result pushed at edge N into an empty, granted buffer SHALL appear with cdbValid=1 after edge N+1; bypass from input to cdb is forbidden.
REQ-020 Simultaneous push and pop on one buffer SHALL be legal, leaving count unchanged; read/write pointers wrap modulo DEPTH.
REQ-021 Per-buffer order SHALL be FIFO; no ordering is guaranteed across requesters.
REQ-022 On a flush edge, all counts SHALL clear, pushes that edge SHALL be dropped, cdbValid SHALL be 0 next cycle, and pointer SHALL reset to 0.
REQ-023 Push attempts while reqReady[i]=0 SHALL be ignored without state change.

Reset
REQ-024 Asserting reset SHALL immediately clear all counts, buffer pointers and the arbitration pointer, drive reqReady=4'b1111 and set every cdb output to 0.
REQ-025 Reset asserted mid-operation SHALL discard buffered results with no partial broadcast.

Structure
REQ-026 Package cdb_pkg SHALL hold NREQ=4, the requester-index enum (ALU, BRANCH, LSU, MUL) and a packed payload struct (result, rob, target, isControl, pcControl).
REQ-027 Sub-module cdb_result_fifo (DEPTH entries, push/pop/count/head) SHALL be instantiated once per requester.

Verification
REQ-028 After reset, ALU pushes result 0x0000_0011 rob 3 -> next cycle cdbValid=1, cdbResult=0x11, cdbRob=3, cdbSource=0.
REQ-029 All four push at one edge, pointer 0 -> cdbSource sequence 0,1,2,3 on consecutive cycles, then cdbValid=0.
REQ-030 Branch pushes 3 results with no ALU/LSU/MUL traffic -> reqReady[1]=0 after 2 pushes with 0 pops outstanding; third held by requester; all three broadcast in order.
REQ-031 Buffers hold 5 entries, flush pulsed with reqValid=4'b1111 -> next cycle cdbValid=0, reqReady=4'b1111, nothing later broadcast.
REQ-032 Branch push isControl=1, target 0x0000_0400 -> cdbIsControl=1, cdbTarget=0x400, cdbPcControl equal to pushed value.
REQ-033 Reset asserted asynchronously between edges with 3 entries buffered -> outputs 0 immediately; no broadcast after release.

Source files
------------

// File: rtl/cdb_pkg.sv
// Shared definitions for the common-data-bus scheduler: requester indices,
// default field geometry and the payload layout carried on the bus.
package cdb_pkg;

    localparam int NREQ        = 4;
    localparam int CDB_WIDTH   = 31;
    localparam int CDB_ROB     = 2;
    localparam int CDB_CONTROL = 5;

    typedef enum logic [1:0] {
        REQ_ALU    = 2'd0,
        REQ_BRANCH = 2'd1,
        REQ_LSU    = 2'd2,
        REQ_MUL    = 2'd3
    } req_idx_e;

    // Field order matches the flat payload vector packed inside the scheduler.
    typedef struct packed {
        logic [CDB_WIDTH:0]   result;
        logic [CDB_ROB:0]     rob;
        logic [CDB_WIDTH:0]   target;
        logic                 isControl;
        logic [CDB_CONTROL:0] pcControl;
    } cdb_payload_t;

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/cdb_result_fifo.sv
// Small per-requester result buffer; pointers wrap naturally since DEPTH is a power of two.
module cdb_result_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               data_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [W-1:0]               head_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    assign do_push = push_i && (cnt_q < CW'(DEPTH)) && !flush_i;
    assign do_pop  = pop_i && (cnt_q != '0) && !flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/cdb_scheduler.sv
// Arbitrates four functional-unit result buffers round-robin onto a single registered CDB.
module cdb_scheduler
    import cdb_pkg::*;
#(
    parameter int WIDTH   = CDB_WIDTH,
    parameter int ROB     = CDB_ROB,
    parameter int CONTROL = CDB_CONTROL,
    parameter int DEPTH   = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [NREQ-1:0]              reqValid,
    output logic [NREQ-1:0]              reqReady,
    input  logic [NREQ*(WIDTH+1)-1:0]    reqResult,
    input  logic [NREQ*(WIDTH+1)-1:0]    reqTarget,
    input  logic [NREQ*(ROB+1)-1:0]      reqRob,
    input  logic [NREQ-1:0]              reqIsControl,
    input  logic [NREQ*(CONTROL+1)-1:0]  reqPcControl,
    output logic                         cdbValid,
    output logic [WIDTH:0]               cdbResult,
    output logic [WIDTH:0]               cdbTarget,
    output logic [ROB:0]                 cdbRob,
    output logic                         cdbIsControl,
    output logic [CONTROL:0]             cdbPcControl,
    output logic [1:0]                   cdbSource
);
    localparam int PW = 2 * (WIDTH + 1) + (ROB + 1) + 1 + (CONTROL + 1);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [PW-1:0]   head [NREQ];
    logic [CW-1:0]   cnt  [NREQ];
    logic [NREQ-1:0] nonempty, push, pop;

    logic            grant_vld;
    logic [1:0]      grant_idx, cand;

    logic            cdb_vld_q, cdb_vld_d;
    logic [PW-1:0]   payload_q, payload_d;
    logic [1:0]      src_q, src_d;
    logic [1:0]      ptr_q, ptr_d;

    for (genvar g = 0; g < NREQ; g++) begin : g_req
        logic [PW-1:0] din;
        assign din = {reqResult[g*(WIDTH+1) +: WIDTH+1],
                      reqRob[g*(ROB+1) +: ROB+1],
                      reqTarget[g*(WIDTH+1) +: WIDTH+1],
                      reqIsControl[g],
                      reqPcControl[g*(CONTROL+1) +: CONTROL+1]};

        assign reqReady[g] = (cnt[g] < CW'(DEPTH));
        assign nonempty[g] = (cnt[g] != '0);
        assign push[g]     = reqValid[g] && reqReady[g];
        assign pop[g]      = grant_vld && (grant_idx == 2'(g));

        cdb_result_fifo #(.W(PW), .DEPTH(DEPTH)) u_fifo (
            .clk_i   (clk),
            .rst_i   (reset),
            .flush_i (flush),
            .push_i  (push[g]),
            .pop_i   (pop[g]),
            .data_i  (din),
            .count_o (cnt[g]),
            .head_o  (head[g])
        );
    end

    // Scan from the farthest offset down so the nearest non-empty buffer after ptr_q wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = ptr_q;
        cand      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = ptr_q + 2'(k);
            if (nonempty[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        cdb_vld_d = grant_vld && !flush;
        payload_d = payload_q;
        src_d     = src_q;
        ptr_d     = ptr_q;
        if (flush) begin
            ptr_d = '0;
        end else if (grant_vld) begin
            payload_d = head[grant_idx];
            src_d     = grant_idx;
            ptr_d     = rr_next(grant_idx);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cdb_vld_q <= 1'b0;
            payload_q <= '0;
            src_q     <= '0;
            ptr_q     <= '0;
        end else begin
            cdb_vld_q <= cdb_vld_d;
            payload_q <= payload_d;
            src_q     <= src_d;
            ptr_q     <= ptr_d;
        end
    end

    assign cdbValid  = cdb_vld_q;
    assign cdbSource = src_q;
    assign {cdbResult, cdbRob, cdbTarget, cdbIsControl, cdbPcControl} = payload_q;

endmodule
